// File: rtl/pipelined_addsub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pipelined_addsub
// Description : Segmented add/subtract pipeline, one SEG-bit slice per stage,
//               with ALU flags and valid/ready handshake on both sides.
// Revision    : 1.0
// ============================================================================
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int c_seg    = (SEG < 1) ? 1 : SEG;
    localparam int c_stages = ((WIDTH / c_seg) < 1) ? 1 : (WIDTH / c_seg);
    localparam int c_last   = c_stages - 1;

    if ((SEG < 1) || ((WIDTH % c_seg) != 0)) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a positive integer multiple of SEG");
    end

    // Operands shift right by one segment per stage so the live slice is always
    // at [c_seg-1:0]; result slices shift in from the top and land in order.
    logic             r_v   [c_stages];
    logic             r_c   [c_stages];
    logic [WIDTH-1:0] r_a   [c_stages];
    logic [WIDTH-1:0] r_b   [c_stages];
    logic [WIDTH-1:0] r_s   [c_stages];
    logic             r_ovf;
    logic             r_zero;

    logic             w_vi    [c_stages];
    logic             w_ci    [c_stages];
    logic [WIDTH-1:0] w_ain   [c_stages];
    logic [WIDTH-1:0] w_bin   [c_stages];
    logic [WIDTH-1:0] w_sin   [c_stages];
    logic [WIDTH-1:0] w_snext [c_stages];
    logic [c_seg:0]   w_seg   [c_stages];

    logic [WIDTH-1:0] w_bp;
    logic             w_c0;
    logic             w_stall;
    logic             w_msb_cin;
    logic             w_ovf;
    logic             w_zero;

    assign w_bp    = sub ? ~b : b;
    assign w_c0    = sub | cin;
    assign w_stall = r_v[c_last] & ~out_ready;

    always_comb begin
        w_vi[0]  = in_valid;
        w_ci[0]  = w_c0;
        w_ain[0] = a;
        w_bin[0] = w_bp;
        w_sin[0] = '0;
        for (int k = 1; k < c_stages; k++) begin
            w_vi[k]  = r_v[k-1];
            w_ci[k]  = r_c[k-1];
            w_ain[k] = r_a[k-1];
            w_bin[k] = r_b[k-1];
            w_sin[k] = r_s[k-1];
        end
        for (int k = 0; k < c_stages; k++) begin
            w_seg[k]   = {1'b0, w_ain[k][c_seg-1:0]} + {1'b0, w_bin[k][c_seg-1:0]}
                       + {{c_seg{1'b0}}, w_ci[k]};
            w_snext[k] = (w_sin[k] >> c_seg)
                       | (WIDTH'(w_seg[k][c_seg-1:0]) << (WIDTH - c_seg));
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign w_msb_cin = w_ain[c_last][c_seg-1] ^ w_bin[c_last][c_seg-1] ^ w_seg[c_last][c_seg-1];
    assign w_ovf     = w_msb_cin ^ w_seg[c_last][c_seg];
    assign w_zero    = (w_snext[c_last] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < c_stages; k++) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (!w_stall) begin
            for (int k = 0; k < c_stages; k++) begin
                r_v[k] <= w_vi[k];
                r_c[k] <= w_seg[k][c_seg];
                r_a[k] <= w_ain[k] >> c_seg;
                r_b[k] <= w_bin[k] >> c_seg;
                r_s[k] <= w_snext[k];
            end
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign in_ready  = ~w_stall;
    assign out_valid = r_v[c_last];
    assign sum       = r_s[c_last];
    assign cout      = r_c[c_last];
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_s[c_last][WIDTH-1];

endmodule
`default_nettype wire
